// File: rtl/nonce_rr_scheduler.sv
// rtl/nonce_rr_scheduler.sv - per-source nonce hold slots, round-robin into a FIFO, drained to serial_transmit
// Optional feature macro: NONCE_DROP_CNT_EN adds the saturating drop_count output.
module nonce_rr_scheduler #(
  parameter int SLAVES    = 2,
  parameter int FIFO_LOG2 = 3,
  parameter int BUSY_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SLAVES-1:0]    new_nonces,
  input  logic [SLAVES*32-1:0] slave_nonces,
  input  logic                 serial_busy,
  output logic                 serial_send,
  output logic [31:0]          golden_nonce,
  output logic [SLAVES-1:0]    pending,
  output logic [FIFO_LOG2:0]   fifo_level,
  output logic                 overflow
`ifdef NONCE_DROP_CNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int GW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int HW    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_SEND  = 4'b0010;
  localparam logic [3:0] ST_HOLD  = 4'b0100;
  localparam logic [3:0] ST_DRAIN = 4'b1000;

  localparam logic [FIFO_LOG2:0]   LVL_ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2:0]   LVL_FULL = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
  localparam logic [HW-1:0]        HC_ONE   = HW'(1);
  localparam logic [HW-1:0]        HC_LAST  = HW'(BUSY_WAIT - 1);

  logic [31:0]          hold [SLAVES];
  logic [GW-1:0]        last_grant;
  logic                 grant_valid;
  logic [GW-1:0]        grant_idx;
  logic [SLAVES-1:0]    grant_vec;
  logic [SLAVES-1:0]    overwrite_vec;

  logic [31:0]          fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  logic [3:0]           state;
  logic [HW-1:0]        hold_cnt;

  assign fifo_full  = (fifo_level == LVL_FULL);
  assign fifo_empty = (fifo_level == '0);

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_l;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    idx         = 0;
    idx_l       = '0;
    if (!fifo_full) begin
      for (int k = 1; k <= SLAVES; k++) begin
        idx   = (int'(last_grant) + k) % SLAVES;
        idx_l = GW'(idx);
        if (!grant_valid && pending[idx_l]) begin
          grant_valid = 1'b1;
          grant_idx   = idx_l;
        end
      end
    end
    if (grant_valid) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign push          = grant_valid;
  assign pop           = (state == ST_IDLE) && !fifo_empty && !serial_busy;
  assign overwrite_vec = new_nonces & pending & ~grant_vec;

  // A granted slot hands its old word to the FIFO while it captures a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      last_grant <= GW'(SLAVES - 1);
      overflow   <= 1'b0;
      for (int i = 0; i < SLAVES; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          hold[i]    <= slave_nonces[i*32 +: 32];
          pending[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        last_grant <= grant_idx;
      end
      if (|overwrite_vec) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= hold[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_ONE;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_ONE;
      end
    end
  end

  // HOLD gives up on busy after BUSY_WAIT quiet cycles and treats the word as sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      serial_send  <= 1'b0;
      golden_nonce <= '0;
      hold_cnt     <= '0;
    end else begin
      serial_send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            golden_nonce <= fifo_mem[rd_ptr];
            serial_send  <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          hold_cnt <= '0;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (serial_busy) begin
            state <= ST_DRAIN;
          end else if (hold_cnt == HC_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HC_ONE;
          end
        end
        ST_DRAIN: begin
          if (!serial_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NONCE_DROP_CNT_EN
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < SLAVES; i++) begin
      drop_sum = drop_sum + {16'd0, overwrite_vec[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_nonce_rr_scheduler.sv
// tb/tb_nonce_rr_scheduler.sv - self-checking bench for nonce_rr_scheduler with a queue-based reference model
// Honours NONCE_DROP_CNT_EN to cover drop_count.
module tb_nonce_rr_scheduler;

  localparam int SLAVES    = 2;
  localparam int FIFO_LOG2 = 3;
  localparam int BUSY_WAIT = 3;
  localparam int DEPTH     = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_SEND  = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_DRAIN = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [SLAVES-1:0]    new_nonces = '0;
  logic [SLAVES*32-1:0] slave_nonces = '0;
  logic                 serial_busy;
  logic                 serial_send;
  logic [31:0]          golden_nonce;
  logic [SLAVES-1:0]    pending;
  logic [FIFO_LOG2:0]   fifo_level;
  logic                 overflow;
`ifdef NONCE_DROP_CNT_EN
  logic [15:0]          drop_count;
`endif

  logic force_busy = 1'b0;
  logic resp_busy  = 1'b0;
  logic resp_en    = 1'b0;
  int   resp_cnt   = 0;
  int   resp_len   = 2;
  logic cmp_en     = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sent_q[$];

  assign serial_busy = force_busy | resp_busy;

  nonce_rr_scheduler #(
    .SLAVES(SLAVES),
    .FIFO_LOG2(FIFO_LOG2),
    .BUSY_WAIT(BUSY_WAIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .new_nonces(new_nonces),
    .slave_nonces(slave_nonces),
    .serial_busy(serial_busy),
    .serial_send(serial_send),
    .golden_nonce(golden_nonce),
    .pending(pending),
    .fifo_level(fifo_level),
    .overflow(overflow)
`ifdef NONCE_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Serial transmitter stand-in: busy for resp_len cycles starting the cycle after a send strobe.
  always @(posedge clk) begin
    #1;
    if (resp_cnt > 0) begin
      resp_busy = 1'b1;
      resp_cnt  = resp_cnt - 1;
    end else begin
      resp_busy = 1'b0;
    end
    if (serial_send && resp_en) resp_cnt = resp_len;
  end

  // Reference model state
  logic [31:0]       m_hold [SLAVES];
  logic [SLAVES-1:0] m_pend = '0;
  logic [31:0]       m_fifo[$];
  int                m_last = SLAVES - 1;
  logic              m_overflow = 1'b0;
  int                m_drops = 0;
  int                m_phase = PH_IDLE;
  int                m_quiet = 0;
  logic              m_send = 1'b0;
  logic [31:0]       m_golden = '0;

  task automatic model_reset();
    m_pend = '0;
    m_fifo.delete();
    m_last = SLAVES - 1;
    m_overflow = 1'b0;
    m_drops = 0;
    m_phase = PH_IDLE;
    m_quiet = 0;
    m_send = 1'b0;
    m_golden = '0;
  endtask

  task automatic model_step();
    int g;
    logic [SLAVES-1:0] old_pend;
    g = -1;
    old_pend = m_pend;
    if (m_fifo.size() < DEPTH) begin
      for (int k = 1; k <= SLAVES; k++) begin
        if (g < 0 && m_pend[(m_last + k) % SLAVES]) g = (m_last + k) % SLAVES;
      end
    end
    m_send = 1'b0;
    case (m_phase)
      PH_IDLE: if (m_fifo.size() != 0 && !serial_busy) begin
        m_golden = m_fifo.pop_front();
        m_send = 1'b1;
        m_phase = PH_SEND;
      end
      PH_SEND: begin
        m_phase = PH_HOLD;
        m_quiet = 0;
      end
      PH_HOLD: if (serial_busy) m_phase = PH_DRAIN;
               else begin
                 m_quiet++;
                 if (m_quiet >= BUSY_WAIT) m_phase = PH_IDLE;
               end
      PH_DRAIN: if (!serial_busy) m_phase = PH_IDLE;
      default: m_phase = PH_IDLE;
    endcase
    if (g >= 0) begin
      m_fifo.push_back(m_hold[g]);
      m_pend[g] = 1'b0;
      m_last = g;
    end
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i]) begin
        if (old_pend[i] && g != i) begin
          m_overflow = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        m_hold[i] = slave_nonces[i*32 +: 32];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("serial_send", 32'(serial_send), 32'(m_send));
      chk("golden_nonce", golden_nonce, m_golden);
      chk("pending", 32'(pending), 32'(m_pend));
      chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
      chk("overflow", 32'(overflow), 32'(m_overflow));
      chk("send_while_busy", 32'(serial_send & serial_busy), 32'd0);
`ifdef NONCE_DROP_CNT_EN
      chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
      if (serial_send) sent_q.push_back(golden_nonce);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [SLAVES-1:0] v, input logic [31:0] n0, input logic [31:0] n1);
    new_nonces = v;
    slave_nonces = {n1, n0};
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    pulse('0, '0, '0);
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] sent_at(input int idx);
    return (idx < sent_q.size()) ? sent_q[idx] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [11:0] send_vec;
    resp_en = 1'b1;
    resp_len = 2;
    do_reset();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_send", 32'(serial_send), 32'd0);
    chk("reset_golden", golden_nonce, 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Test 1: single word latency
    sent_q.delete();
    cyc(); pulse(2'b01, 32'hDEADBEEF, 32'h0);
    cyc(); pulse('0, '0, '0);
    @(negedge clk); chk("t1_pend_c1", 32'(pending), 32'd1);
    cyc(); @(negedge clk); chk("t1_level_c2", 32'(fifo_level), 32'd1);
    chk("t1_nosend_c2", 32'(serial_send), 32'd0);
    cyc(); @(negedge clk);
    chk("t1_send_c3", 32'(serial_send), 32'd1);
    chk("t1_golden_c3", golden_nonce, 32'hDEADBEEF);
    chk("t1_level_c3", 32'(fifo_level), 32'd0);
    repeat (20) cyc();

    // Test 2: simultaneous sources, order 11 then 22
    do_reset();
    sent_q.delete();
    cyc(); pulse(2'b11, 32'h11, 32'h22);
    cyc(); pulse('0, '0, '0);
    repeat (30) cyc();
    chk("t2_count", 32'(sent_q.size()), 32'd2);
    chk("t2_first", sent_at(0), 32'h11);
    chk("t2_second", sent_at(1), 32'h22);

    // Test 3: busy held, src0 floods, src1 still served early
    force_busy = 1'b1;
    do_reset();
    sent_q.delete();
    for (int c = 0; c < 10; c++) begin
      cyc();
      pulse((c == 0) ? 2'b11 : 2'b01, 32'h100 + c, 32'h200);
    end
    cyc(); pulse('0, '0, '0);
    @(negedge clk); chk("t3_level_full", 32'(fifo_level), 32'd8);
    cyc(); force_busy = 1'b0;
    repeat (100) cyc();
    chk("t3_count", 32'(sent_q.size()), 32'd9);
    chk("t3_first", sent_at(0), 32'h100);
    chk("t3_src1", sent_at(1), 32'h200);
    chk("t3_last", sent_at(8), 32'h109);

    // Test 4: FIFO full, A then B overwrites the hold slot
    force_busy = 1'b1;
    do_reset();
    sent_q.delete();
    for (int c = 0; c < 8; c++) begin
      cyc();
      pulse(2'b01, 32'h300 + c, 32'h0);
    end
    cyc(); pulse('0, '0, '0);
    cyc(); pulse(2'b01, 32'hAAAA_AAAA, 32'h0);
    cyc(); pulse(2'b01, 32'hBBBB_BBBB, 32'h0);
    cyc(); pulse('0, '0, '0);
    @(negedge clk);
    chk("t4_pending", 32'(pending), 32'd1);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_level", 32'(fifo_level), 32'd8);
`ifdef NONCE_DROP_CNT_EN
    chk("t4_drop_count", 32'(drop_count), 32'd1);
`endif
    cyc(); force_busy = 1'b0;
    repeat (100) cyc();
    chk("t4_count", 32'(sent_q.size()), 32'd9);
    chk("t4_first", sent_at(0), 32'h300);
    chk("t4_hold_b", sent_at(8), 32'hBBBB_BBBB);

    // Test 5: busy never rises, HOLD times out after BUSY_WAIT cycles
    resp_en = 1'b0;
    do_reset();
    sent_q.delete();
    send_vec = '0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (c == 0) pulse(2'b01, 32'h5555_0001, 32'h0);
      else if (c == 1) pulse(2'b01, 32'h5555_0002, 32'h0);
      else pulse('0, '0, '0);
      @(negedge clk);
      send_vec[c] = serial_send;
    end
    chk("t5_send_pattern", 32'(send_vec), 32'h108);
    chk("t5_first", sent_at(0), 32'h5555_0001);
    chk("t5_second", sent_at(1), 32'h5555_0002);
    repeat (10) cyc();

    // Test 6: reset during DRAIN with five words queued
    resp_en = 1'b1;
    resp_len = 6;
    do_reset();
    sent_q.delete();
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c < 6) pulse(2'b01, 32'h600 + c, 32'h0);
      else pulse('0, '0, '0);
    end
    @(negedge clk); chk("t6_level_before", 32'(fifo_level), 32'd5);
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_send", 32'(serial_send), 32'd0);
    chk("t6_rst_golden", golden_nonce, 32'd0);
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_overflow", 32'(overflow), 32'd0);
    cyc(); rst_n = 1'b1;
    sent_q.delete();
    for (int c = 0; c < 20; c++) begin
      cyc();
      @(negedge clk);
      chk("t6_no_send", 32'(serial_send), 32'd0);
    end
    cyc(); pulse(2'b10, 32'h0, 32'h777);
    cyc(); pulse('0, '0, '0);
    repeat (20) cyc();
    chk("t6_after_count", 32'(sent_q.size()), 32'd1);
    chk("t6_after_word", sent_at(0), 32'h777);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
